// File: rtl/pipe_adder.sv
// Segmented pipelined adder with valid/ready flow control; one SEG-bit slice per stage.
// Define PIPE_ADDER_OVF_EN to add the signed-overflow output ovf.
module pipe_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int SEG = WIDTH / STAGES;

    logic advance;

    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits below k*SEG are already consumed, so only the
        // remaining upper REM bits travel into this stage.
        localparam int REM = WIDTH - k * SEG;

        logic [REM-1:0]   a_in;
        logic [REM-1:0]   b_in;
        logic [WIDTH-1:0] s_in;
        logic             c_in;
        logic             v_in;
        logic [SEG:0]     seg;
        logic [WIDTH-1:0] s_nx;
        logic [WIDTH-1:0] s_r;
        logic             c_r;
        logic             v_r;

        if (k == 0) begin : g_src
            assign a_in = A;
            assign b_in = B;
            assign s_in = '0;
            assign c_in = cin;
            assign v_in = in_valid;
        end else begin : g_src
            assign a_in = g_stage[k-1].g_rest.a_r;
            assign b_in = g_stage[k-1].g_rest.b_r;
            assign s_in = g_stage[k-1].s_r;
            assign c_in = g_stage[k-1].c_r;
            assign v_in = g_stage[k-1].v_r;
        end

        assign seg = {1'b0, a_in[SEG-1:0]}
                   + {1'b0, b_in[SEG-1:0]}
                   + {{SEG{1'b0}}, c_in};

        always_comb begin
            s_nx = s_in;
            s_nx[k*SEG +: SEG] = seg[SEG-1:0];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_r <= '0;
                c_r <= 1'b0;
                v_r <= 1'b0;
            end else if (advance) begin
                s_r <= s_nx;
                c_r <= seg[SEG];
                v_r <= v_in;
            end
        end

        if (k < STAGES - 1) begin : g_rest
            logic [REM-SEG-1:0] a_r;
            logic [REM-SEG-1:0] b_r;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_r <= '0;
                    b_r <= '0;
                end else if (advance) begin
                    a_r <= a_in[REM-1:SEG];
                    b_r <= b_in[REM-1:SEG];
                end
            end
        end

`ifdef PIPE_ADDER_OVF_EN
        // The operand MSBs reach the last stage with the top segment.
        if (k == STAGES - 1) begin : g_sign
            logic sa_r;
            logic sb_r;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sa_r <= 1'b0;
                    sb_r <= 1'b0;
                end else if (advance) begin
                    sa_r <= a_in[REM-1];
                    sb_r <= b_in[REM-1];
                end
            end
        end
`endif
    end

    assign sum       = g_stage[STAGES-1].s_r;
    assign cout      = g_stage[STAGES-1].c_r;
    assign out_valid = g_stage[STAGES-1].v_r;

`ifdef PIPE_ADDER_OVF_EN
    assign ovf = (g_stage[STAGES-1].g_sign.sa_r == g_stage[STAGES-1].g_sign.sb_r)
              && (sum[WIDTH-1] != g_stage[STAGES-1].g_sign.sa_r);
`endif

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/sum width in bits (>= 2).
REQ-002 SHALL have parameter STAGES, default 2, pipeline stage count; WIDTH % STAGES == 0, segment width SEG = WIDTH/STAGES.
REQ-003 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand beat offered.
REQ-006 SHALL have port in_ready  output  1  operand beat accepted this cycle when high with in_valid.
REQ-007 SHALL have port A  input  WIDTH  first operand, unsigned (two's complement when overflow feature enabled).
REQ-008 SHALL have port B  input  WIDTH  second operand.
REQ-009 SHALL have port cin  input  1  carry in.
REQ-010 SHALL have port out_valid  output  1  result beat present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port sum  output  WIDTH  A+B+cin modulo 2^WIDTH.
REQ-013 SHALL have port cout  output  1  carry out of bit WIDTH-1.
REQ-014 SHALL have port ovf  output  1  signed overflow; present only under PIPE_ADDER_OVF_EN.

Function
REQ-015 SHALL compute segment k (bits k*SEG..k*SEG+SEG-1) in stage k using the registered carry from stage k-1; stage 0 uses cin.
REQ-016 SHALL carry unconsumed operand segments and completed sum segments forward in per-stage registers with a per-stage valid bit.
REQ-017 SHALL define advance = out_ready OR NOT out_valid; all stage registers load only when advance is high, else hold.
REQ-018 SHALL drive in_ready = advance (combinational; no combinational path from in_valid to in_ready).
REQ-019 SHALL capture a beat when in_valid AND in_ready; stage-0 valid loads in_valid on advance, so bubbles propagate.
REQ-020 SHALL present a result exactly STAGES cycles after capture when out_ready held high; throughput one beat per cycle.
REQ-021 SHALL keep sum, cout, ovf, out_valid stable while out_valid high and out_ready low.
REQ-022 SHALL preserve beat order; no beat dropped or duplicated under any out_ready pattern.
REQ-023 SHALL produce cout=1 and sum wrapped modulo 2^WIDTH when A+B+cin >= 2^WIDTH.
REQ-024 SHALL, when in_valid rises in the same cycle out_ready releases a stalled result, accept the new beat and retire the old one in that cycle.
REQ-025 SHALL ignore A, B, cin when in_valid is low or in_ready is low.

Reset
REQ-026 SHALL, on rst_n low, asynchronously clear all stage valid bits, data and carry registers; out_valid=0, sum=0, cout=0, ovf=0.
REQ-027 SHALL discard all in-flight beats on reset mid-operation; first result after release is from a beat captured after release.
REQ-028 SHALL hold in_ready=1 during reset (out_valid=0), but capture nothing until rst_n high.

Configuration
REQ-029 SHALL, with PIPE_ADDER_OVF_EN defined, add port ovf = (A[W-1]==B[W-1]) AND (sum[W-1]!=A[W-1]), sign bits pipelined alongside the beat, same latency as sum.
REQ-030 SHALL, without PIPE_ADDER_OVF_EN, omit ovf port and its registers; all other behaviour identical.

Verification (WIDTH=8, STAGES=2, out_ready=1 unless stated)
REQ-031 SHALL check A=0x00, B=0xFF, cin=0 -> sum=0xFF, cout=0, out_valid exactly 2 cycles after capture.
REQ-032 SHALL check back-to-back A=0xFF,B=0x01,cin=0 then A=0x0F,B=0x01,cin=1 -> 0x00/cout=1 then 0x11/cout=0 on consecutive cycles (inter-segment carry).
REQ-033 SHALL check out_ready=0 for 5 cycles with 3 beats offered -> in_ready=0 after pipeline fills, first result held stable, all 3 results delivered in order after release.
REQ-034 SHALL check rst_n pulsed low with 2 beats in flight -> out_valid=0 immediately, no stale result after release.
REQ-035 SHALL check with PIPE_ADDER_OVF_EN: A=0x7F,B=0x01 -> sum=0x80, ovf=1; A=0x80,B=0x80 -> sum=0x00, cout=1, ovf=1; A=0x05,B=0x03 -> ovf=0.
REQ-036 SHALL run 10k random beats with random in_valid/out_ready against a reference A+B+cin model, zero mismatches.
